ram_port_arbiter: RTL and testbench

//  Two-requester controller for the single-port ram (ADDR_W x DATA_W, ports data_out/data_in/addr/wr/cs).

---
 rtl/ram_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that sequences two requesters onto one single-port ram.
// Optional power-up zero fill of the ram is enabled by defining RAM_CLEAR_EN.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wr,
  output logic              ram_cs,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    StIdle,
    StAccess,
    StResp
`ifdef RAM_CLEAR_EN
    ,
    StClrInit,
    StClrWr,
    StClrGap
`endif
  } state_e;

`ifdef RAM_CLEAR_EN
  localparam state_e ResetState = StClrInit;
`else
  localparam state_e ResetState = StIdle;
`endif

  state_e              state_q, state_d;
  logic                op_wr_q, op_wr_d;
  // 1 = B was granted last (and is the current winner while an access runs).
  logic                last_b_q, last_b_d;
  logic                cs_q, cs_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic                pick_b;

  always_comb begin
    state_d  = state_q;
    op_wr_d  = op_wr_q;
    last_b_d = last_b_q;
    cs_d     = 1'b0;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    rdata_d  = rdata_q;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;
    pick_b   = b_req && (!a_req || !last_b_q);

    unique case (state_q)
      StIdle: begin
        if (a_req || b_req) begin
          state_d  = StAccess;
          last_b_d = pick_b;
          op_wr_d  = pick_b ? b_wr : a_wr;
          addr_d   = pick_b ? b_addr : a_addr;
          din_d    = pick_b ? b_wdata : a_wdata;
          cs_d     = 1'b1;
          wr_d     = pick_b ? b_wr : a_wr;
        end
      end
      StAccess: begin
        state_d = StResp;
        if (!op_wr_q) rdata_d = ram_dout;
        a_ack_d = !last_b_q;
        b_ack_d = last_b_q;
      end
      StResp: begin
        state_d = StIdle;
      end
`ifdef RAM_CLEAR_EN
      StClrInit: begin
        state_d = StClrWr;
        addr_d  = '0;
        din_d   = '0;
        cs_d    = 1'b1;
        wr_d    = 1'b1;
      end
      StClrWr: begin
        state_d = StClrGap;
        addr_d  = addr_q + ADDR_W'(1);
      end
      StClrGap: begin
        // Address wraps to zero only after the last location has been written.
        if (addr_q == '0) begin
          state_d = StIdle;
        end else begin
          state_d = StClrWr;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ResetState;
      op_wr_q  <= 1'b0;
      last_b_q <= 1'b1;
      cs_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rdata_q  <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_wr_q  <= op_wr_d;
      last_b_q <= last_b_d;
      cs_q     <= cs_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
    end
  end

`ifdef RAM_CLEAR_EN
  logic busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b1;
    end else begin
      busy_q <= (state_d == StClrInit) || (state_d == StClrWr) || (state_d == StClrGap);
    end
  end

  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  assign ram_cs   = cs_q;
  assign ram_wr   = wr_q;
  assign ram_addr = addr_q;
  assign ram_din  = din_q;
  assign rdata    = rdata_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter against a queue-free round-robin/memory model.
module tb_ram_port_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              a_req, a_wr, b_req, b_wr;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_ack, b_ack, busy, ram_wr, ram_cs;
  logic [DATA_W-1:0] rdata, ram_din, ram_dout;
  logic [ADDR_W-1:0] ram_addr;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
    .rdata(rdata), .busy(busy), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_wr(ram_wr), .ram_cs(ram_cs), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural ram: asynchronous read, write on clock edge with cs&wr.
  logic [DATA_W-1:0] ram_mem [DEPTH];
  always @(posedge clk) if (ram_cs && ram_wr) ram_mem[ram_addr] <= ram_din;
  assign ram_dout = ram_mem[ram_addr];

  // Reference model state.
  logic [DATA_W-1:0] ref_mem   [DEPTH];
  bit                ref_valid [DEPTH];
  bit                last_b;
  int                n_checks = 0;
  int                n_err    = 0;

  bit                op_wr   [2];
  logic [ADDR_W-1:0] op_addr [2];
  logic [DATA_W-1:0] op_wd   [2];
  int                rem     [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    a_req = (rem[0] > 0); a_wr = op_wr[0]; a_addr = op_addr[0]; a_wdata = op_wd[0];
    b_req = (rem[1] > 0); b_wr = op_wr[1]; b_addr = op_addr[1]; b_wdata = op_wd[1];
  endtask

  task automatic new_op(input int p);
    op_wr[p]   = 1'($urandom_range(0, 1));
    op_addr[p] = ADDR_W'($urandom_range(0, DEPTH - 1));
    op_wd[p]   = DATA_W'($urandom);
  endtask

  // Issues the pending ops of both ports; entered and left in an idle cycle.
  task automatic run_engine(input bit rand_next);
    int guard = 0;
    int since = 0;
    bit first = 1'b1;
    int n_cs = 0, n_wr = 0, n_ops = 0, n_wops = 0;
    int p;
    bit exp_p;
    drive_reqs();
    while ((rem[0] > 0 || rem[1] > 0) && guard < 400) begin
      @(posedge clk); #1;
      guard++; since++;
      if (ram_cs) n_cs++;
      if (ram_wr) n_wr++;
      check("ack_excl", 32'(a_ack & b_ack), 0);
      if (a_ack || b_ack) begin
        p = b_ack ? 1 : 0;
        exp_p = (rem[0] > 0 && rem[1] > 0) ? !last_b : (rem[1] > 0);
        check("grant", p, 32'(exp_p));
        check("latency", since, first ? 2 : 3);
        last_b = exp_p;
        if (rem[p] > 0) begin
          n_ops++;
          if (op_wr[p]) begin
            n_wops++;
            ref_mem[op_addr[p]]   = op_wd[p];
            ref_valid[op_addr[p]] = 1'b1;
          end else if (ref_valid[op_addr[p]]) begin
            check("rdata", 32'(rdata), 32'(ref_mem[op_addr[p]]));
          end
          rem[p]--;
          if (rem[p] > 0 && rand_next) new_op(p);
        end
        since = 0;
        first = 1'b0;
        drive_reqs();
      end
    end
    check("no_timeout", 32'(guard < 400), 1);
    check("cs_cycles", n_cs, n_ops);
    check("wr_cycles", n_wr, n_wops);
    rem[0] = 0; rem[1] = 0;
    drive_reqs();
    @(posedge clk); #1;
  endtask

  task automatic single(input int p, input bit wr, input int addr, input int wd);
    rem[0] = 0; rem[1] = 0; rem[p] = 1;
    op_wr[p] = wr; op_addr[p] = ADDR_W'(addr); op_wd[p] = DATA_W'(wd);
    run_engine(1'b0);
  endtask

  task automatic wait_ready();
    last_b = 1'b1;
`ifdef RAM_CLEAR_EN
    int cnt = 0;
    while (busy && cnt < 3000) begin
      check("no_ack_busy", 32'(a_ack | b_ack), 0);
      @(posedge clk); #1;
      cnt++;
    end
    check("clear_len", 32'(cnt >= 2048 && cnt <= 2050), 1);
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0; ref_valid[i] = 1'b1;
    end
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {28'd0, ram_cs, ram_wr, a_ack, b_ack}, 0);
    check({tag, "_addr"}, 32'(ram_addr), 0);
    check({tag, "_din"}, 32'(ram_din), 0);
    check({tag, "_rdata"}, 32'(rdata), 0);
`ifdef RAM_CLEAR_EN
    check({tag, "_busy"}, 32'(busy), 1);
`else
    check({tag, "_busy"}, 32'(busy), 0);
`endif
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0; ref_valid[i] = 1'b0;
    end
    rem[0] = 0; rem[1] = 0;
    for (int p = 0; p < 2; p++) begin
      op_wr[p] = 1'b0; op_addr[p] = '0; op_wd[p] = '0;
    end
    drive_reqs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_ready();

    // Simultaneous requests right after reset: A,B,A,B,A,B.
    rem[0] = 3; rem[1] = 3;
    new_op(0); new_op(1);
    run_engine(1'b1);

    // Directed write then read-back through A.
    single(0, 1'b1, 5, 8'h0A);
    single(0, 1'b0, 5, 0);
    check("read5", 32'(rdata), 32'h0A);

    // Fill via B, then random reads via A.
    for (int k = 0; k < DEPTH; k++) single(1, 1'b1, k, k * 2);
    for (int i = 0; i < 20; i++) single(0, 1'b0, int'($urandom_range(0, DEPTH - 1)), 0);

    // Reset in the middle of an A write.
    rem[0] = 1; rem[1] = 0;
    op_wr[0] = 1'b1; op_addr[0] = ADDR_W'(7); op_wd[0] = 8'h55;
    drive_reqs();
    @(posedge clk); #1;
    check("mid_cs", 32'(ram_cs), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (3) begin
      @(posedge clk); #1;
      check("mid_no_ack", 32'(a_ack | b_ack), 0);
    end
    rem[0] = 0;
    drive_reqs();
    ref_valid[7] = 1'b0;
    rst_n = 1'b1;
    wait_ready();
    rem[0] = 1; rem[1] = 1;
    op_wr[0] = 1'b0; op_addr[0] = ADDR_W'(9);
    op_wr[1] = 1'b0; op_addr[1] = ADDR_W'(11);
    run_engine(1'b0);
    single(0, 1'b1, 7, 8'h55);
    single(1, 1'b0, 7, 0);

    // Random mix of single, tied and back-to-back traffic.
    for (int r = 0; r < 40; r++) begin
      rem[0] = $urandom_range(0, 3);
      rem[1] = $urandom_range(0, 3);
      new_op(0); new_op(1);
      if (rem[0] > 0 || rem[1] > 0) run_engine(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
